reduction_vector_feeder: RTL and testbench

Initiator side of the start/finish adder-tree handshake. Accepts a serial stream of 32-bit IEEE-754 words and packs NI of them into the wide `inputs` bus, pulsing `ExE_start` once the vector is complete. It then holds the bus stable, waits for the tree's `ExE_finish`, captures `summation`, and returns the result on a valid/ready output. It sits between the vector source (memory reader / PE array) and the NI-input adder tree.

---
 rtl/reduction_vector_feeder.sv | 131 +++++++++++++
 tb/tb_reduction_vector_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_vector_feeder.sv
// Packs NI serial 32-bit words into the adder-tree input bus, issues ExE_start and returns the captured sum.
// Optional build macro FEEDER_ZERO_PAD_EN: short vectors terminated by in_last, unwritten slots read as zero.
`timescale 1ns/1ps
module reduction_vector_feeder #(
    parameter int unsigned NI = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               ExE_start,
    output logic [NI*32-1:0]   inputs,
    input  logic               ExE_finish,
    input  logic [31:0]        summation,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_sum,
    output logic               busy
);

    localparam int unsigned CW = $clog2(NI);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NI*32-1:0]  inputs_q;
    logic [31:0]       out_sum_q;
    logic              finish_q;
    logic              in_ready_q;
    logic              start_q;
    logic              out_valid_q;
    logic              busy_q;

    logic              accept_d;
    logic              vec_end_d;
    logic              capture_d;
    logic              finish_rise_d;
    logic [CW+4:0]     slot_base_d;

    // NI is a power of two, so slot NI-1-k is simply the bitwise inverse of k.
    assign slot_base_d   = {~cnt_q, 5'b00000};
    assign accept_d      = in_valid && in_ready_q;
    assign finish_rise_d = ExE_finish && !finish_q;

`ifdef FEEDER_ZERO_PAD_EN
    assign vec_end_d = accept_d && ((cnt_q == CW'(NI - 1)) || in_last);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign vec_end_d = accept_d && (cnt_q == CW'(NI - 1));
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (accept_d) begin
                    if (vec_end_d) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (finish_rise_d) begin
                    capture_d = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Handshake outputs are registered from the next state so they follow state_q with no input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            inputs_q    <= '0;
            out_sum_q   <= '0;
            finish_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            finish_q <= ExE_finish;
            if (capture_d)
                out_sum_q <= summation;
            if (accept_d)
                inputs_q[slot_base_d +: 32] <= in_data;
`ifdef FEEDER_ZERO_PAD_EN
            if (state_q == S_HOLD && state_d == S_LOAD)
                inputs_q <= '0;
`endif
            in_ready_q  <= (state_d == S_LOAD);
            start_q     <= (state_d == S_START);
            out_valid_q <= (state_d == S_HOLD);
            busy_q      <= (state_d != S_LOAD);
        end
    end

    assign in_ready  = in_ready_q;
    assign ExE_start = start_q;
    assign inputs    = inputs_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reduction_vector_feeder.sv
// Directed bench for reduction_vector_feeder: NI=4 table vectors and corner sequences, NI=256 full vector.
`timescale 1ns/1ps
module tb_reduction_vector_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         a_in_valid, a_in_ready, a_in_last, a_start, a_finish;
    logic         a_out_valid, a_out_ready, a_busy;
    logic [31:0]  a_in_data, a_sum, a_out_sum;
    logic [127:0] a_inputs;

    logic          b_in_valid, b_in_ready, b_in_last, b_start, b_finish;
    logic          b_out_valid, b_out_ready, b_busy;
    logic [31:0]   b_in_data, b_sum, b_out_sum;
    logic [8191:0] b_inputs;

    reduction_vector_feeder #(.NI(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .ExE_start(a_start), .inputs(a_inputs), .ExE_finish(a_finish), .summation(a_sum),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum), .busy(a_busy)
    );

    reduction_vector_feeder #(.NI(256)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .ExE_start(b_start), .inputs(b_inputs), .ExE_finish(b_finish), .summation(b_sum),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .busy(b_busy)
    );

    typedef struct {
        logic [0:3][31:0] w;
        logic [31:0]      sum;
        logic [127:0]     exp_inputs;
    } vec_t;

    vec_t tbl [4];

    int n_checks = 0;
    int n_fails  = 0;
    int b_start_cnt = 0;

    always @(negedge clk) if (b_start) b_start_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic l);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_last  = l;
        while (!a_in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("send_a_timeout", {127'd0, a_in_ready}, 128'd1);
        tick();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        while (!b_in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("send_b_timeout", {127'd0, b_in_ready}, 128'd1);
        tick();
        b_in_valid = 1'b0;
    endtask

    task automatic release_a();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("rel_out_valid", a_out_valid, 0);
        check("rel_in_ready", a_in_ready, 1);
        check("rel_busy", a_busy, 0);
    endtask

    task automatic run_vec_a(input vec_t v, input int hold_cycles);
        for (int k = 0; k < 4; k++) send_a(v.w[k], 1'b0);
        check("start_pulse", a_start, 1);
        check("start_in_ready", a_in_ready, 0);
        check("start_busy", a_busy, 1);
        tick();
        check("start_once", a_start, 0);
        check("packing", a_inputs, v.exp_inputs);
        repeat (3) tick();
        check("wait_inputs_stable", a_inputs, v.exp_inputs);
        check("wait_no_valid", a_out_valid, 0);
        a_sum    = v.sum;
        a_finish = 1'b1;
        tick();
        check("cap_out_valid", a_out_valid, 1);
        check("cap_out_sum", a_out_sum, v.sum);
        check("cap_in_ready", a_in_ready, 0);
        a_sum    = 32'h0BADF00D;
        a_finish = 1'b0;
        for (int c = 0; c < hold_cycles; c++) begin
            tick();
            check("hold_valid", a_out_valid, 1);
            check("hold_sum", a_out_sum, v.sum);
            check("hold_in_ready", a_in_ready, 0);
        end
        release_a();
    endtask

    initial begin
        tbl[0].w = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        tbl[0].sum = 32'h41200000;
        tbl[0].exp_inputs = 128'h3F800000_40000000_40400000_40800000;
        tbl[1].w = {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        tbl[1].sum = 32'h00000000;
        tbl[1].exp_inputs = 128'h00000000_00000000_00000000_00000000;
        tbl[2].w = {32'h80000000, 32'h7F800000, 32'h7FC00001, 32'h00000001};
        tbl[2].sum = 32'h7FC00000;
        tbl[2].exp_inputs = 128'h80000000_7F800000_7FC00001_00000001;
        tbl[3].w = {32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF};
        tbl[3].sum = 32'hCAFEBABE;
        tbl[3].exp_inputs = 128'hFFFFFFFF_12345678_9ABCDEF0_DEADBEEF;

        rst_n = 1'b0;
        a_in_valid = 0; a_in_last = 0; a_in_data = 0; a_finish = 0; a_sum = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_last = 0; b_in_data = 0; b_finish = 0; b_sum = 0; b_out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_start", a_start, 0);
        check("rst_busy", a_busy, 0);
        check("rst_inputs", a_inputs, 0);
        check("rst_out_sum", a_out_sum, 0);
        check("rst_b_in_ready", b_in_ready, 1);

        // NI=256 full vector of 1.0, tree stub answers 10 cycles after start
        for (int i = 0; i < 256; i++) send_b(32'h3F800000);
        check("b_start_pulse", b_start, 1);
        repeat (10) tick();
        check("b_no_valid_early", b_out_valid, 0);
        b_sum    = 32'h43800000;
        b_finish = 1'b1;
        tick();
        b_finish = 1'b0;
        check("b_out_valid", b_out_valid, 1);
        check("b_out_sum", b_out_sum, 32'h43800000);
        check("b_slot0", b_inputs[8191 -: 32], 32'h3F800000);
        check("b_all_slots", {127'd0, b_inputs == {256{32'h3F800000}}}, 1);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("b_rel_in_ready", b_in_ready, 1);
        check("b_start_count", b_start_cnt, 1);

        // Table vectors; vector 1 is held under 20 cycles of backpressure
        for (int i = 0; i < 4; i++) run_vec_a(tbl[i], (i == 1) ? 20 : 1);

        // Stale finish level: must drop and rise again inside WAIT
        a_finish = 1'b1;
        for (int k = 0; k < 4; k++) send_a(tbl[3].w[k], 1'b0);
        check("stale_start", a_start, 1);
        a_sum = 32'h11111111;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("stale_no_valid", a_out_valid, 0);
        end
        a_finish = 1'b0;
        tick();
        check("stale_drop_no_valid", a_out_valid, 0);
        a_sum    = 32'h22222222;
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        check("stale_valid", a_out_valid, 1);
        check("stale_sum", a_out_sum, 32'h22222222);
        release_a();

`ifdef FEEDER_ZERO_PAD_EN
        send_a(32'hAAAAAAAA, 1'b0);
        send_a(32'hBBBBBBBB, 1'b0);
        send_a(32'hCCCCCCCC, 1'b1);
        check("pad_start", a_start, 1);
        tick();
        check("pad_inputs", a_inputs, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_00000000);
        a_sum    = 32'h33333333;
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        check("pad_sum", a_out_sum, 32'h33333333);
        release_a();
        check("pad_cleared", a_inputs, 0);
`else
        send_a(32'hAAAAAAAA, 1'b1);
        check("last_ignored_start", a_start, 0);
        check("last_ignored_ready", a_in_ready, 1);
        send_a(32'hBBBBBBBB, 1'b0);
        send_a(32'hCCCCCCCC, 1'b0);
        send_a(32'hDDDDDDDD, 1'b0);
        check("last_ignored_full_start", a_start, 1);
        tick();
        check("last_ignored_inputs", a_inputs, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        a_sum    = 32'h33333333;
        a_finish = 1'b1;
        tick();
        a_finish = 1'b0;
        check("last_ignored_sum", a_out_sum, 32'h33333333);
        release_a();
`endif

        // Asynchronous reset while waiting for the tree
        for (int k = 0; k < 4; k++) send_a(tbl[3].w[k], 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rstw_inputs", a_inputs, 0);
        check("rstw_out_valid", a_out_valid, 0);
        check("rstw_busy", a_busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstw_in_ready", a_in_ready, 1);
        check("rstw_out_sum", a_out_sum, 0);
        a_sum    = 32'h44444444;
        a_finish = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rstw_late_finish", a_out_valid, 0);
            check("rstw_late_sum", a_out_sum, 0);
        end
        a_finish = 1'b0;
        tick();
        run_vec_a(tbl[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
